// File: rtl/alu_trace_buffer_if.sv
// Capture, read and status signals of the ALU trace buffer.
// The slave modport is the buffer; the master modport is the ALU tap and consumer side.
interface alu_trace_buffer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16
);
  logic                     clear;
  logic                     cap_en;
  logic [3:0]               alu_op;
  logic [31:0]              in_a;
  logic [31:0]              in_b;
  logic [31:0]              result;
  logic                     zero;

  logic                     rd_valid;
  logic                     rd_ready;
  logic [3:0]               rd_alu_op;
  logic [31:0]              rd_in_a;
  logic [31:0]              rd_in_b;
  logic [31:0]              rd_result;
  logic                     rd_zero;
  logic                     rd_zero_err;
  logic [SEQ_W-1:0]         rd_seq;

  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic [SEQ_W-1:0]         drop_cnt;

  modport slave (
    input  clear, cap_en, alu_op, in_a, in_b, result, zero, rd_ready,
    output rd_valid, rd_alu_op, rd_in_a, rd_in_b, rd_result, rd_zero, rd_zero_err, rd_seq,
    output count, full, empty, drop_cnt
  );

  modport master (
    output clear, cap_en, alu_op, in_a, in_b, result, zero, rd_ready,
    input  rd_valid, rd_alu_op, rd_in_a, rd_in_b, rd_result, rd_zero, rd_zero_err, rd_seq,
    input  count, full, empty, drop_cnt
  );
endinterface

// File: rtl/alu_trace_buffer.sv
// FIFO trace of sampled ALU operations with sequence numbering, drop counting and a
// zero-flag consistency check; first-word-fall-through read port.
module alu_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16
) (
  input logic               clk,
  input logic               reset,
  alu_trace_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [3:0]       alu_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [31:0]      result;
    logic             zero;
    logic             zero_err;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] drop_q;
  logic             full, empty, pop, push, drop, active;

  // Clear and reset both suppress any same-cycle push, pop or drop.
  assign active = !reset && !bus.clear;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = active && !empty && bus.rd_ready;
  assign push   = active && bus.cap_en && (!full || pop);
  assign drop   = active && bus.cap_en && full && !pop;

  always_comb begin
    new_entry          = '0;
    new_entry.alu_op   = bus.alu_op;
    new_entry.in_a     = bus.in_a;
    new_entry.in_b     = bus.in_b;
    new_entry.result   = bus.result;
    new_entry.zero     = bus.zero;
    new_entry.zero_err = bus.zero ^ (bus.result == 32'h0);
    new_entry.seq      = seq_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      // Sequence advances on every sample, kept or dropped.
      if (bus.cap_en) seq_q <= seq_q + SEQ_W'(1);
      if (drop && (drop_q != '1)) drop_q <= drop_q + SEQ_W'(1);
    end
  end

  assign head            = mem[rd_ptr_q];
  assign bus.rd_valid    = !empty;
  assign bus.rd_alu_op   = head.alu_op;
  assign bus.rd_in_a     = head.in_a;
  assign bus.rd_in_b     = head.in_b;
  assign bus.rd_result   = head.result;
  assign bus.rd_zero     = head.zero;
  assign bus.rd_zero_err = head.zero_err;
  assign bus.rd_seq      = head.seq;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_alu_trace_buffer.sv
// Directed bench for alu_trace_buffer: main instance DEPTH=8/SEQ_W=16 and a
// small DEPTH=2/SEQ_W=4 instance for sequence wrap.
module tb_alu_trace_buffer;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  alu_trace_buffer_if #(.DEPTH(8), .SEQ_W(16)) ta ();
  alu_trace_buffer_if #(.DEPTH(2), .SEQ_W(4))  tb4 ();

  alu_trace_buffer #(.DEPTH(8), .SEQ_W(16)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ta.slave)
  );

  alu_trace_buffer #(.DEPTH(2), .SEQ_W(4)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (tb4.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cap(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic z);
    ta.cap_en = 1'b1;
    ta.alu_op = op;
    ta.in_a   = a;
    ta.in_b   = b;
    ta.result = r;
    ta.zero   = z;
  endtask

  initial begin
    reset       = 1'b1;
    ta.clear    = 1'b0;
    ta.cap_en   = 1'b0;
    ta.alu_op   = 4'h0;
    ta.in_a     = '0;
    ta.in_b     = '0;
    ta.result   = '0;
    ta.zero     = 1'b0;
    ta.rd_ready = 1'b0;
    tb4.clear    = 1'b0;
    tb4.cap_en   = 1'b0;
    tb4.alu_op   = 4'h0;
    tb4.in_a     = '0;
    tb4.in_b     = '0;
    tb4.result   = 32'h1;
    tb4.zero     = 1'b0;
    tb4.rd_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_count", ta.count, 0);
    check("rst_empty", ta.empty, 1);
    check("rst_full", ta.full, 0);
    check("rst_rd_valid", ta.rd_valid, 0);
    check("rst_drop", ta.drop_cnt, 0);

    // Basic capture, consumer ready
    ta.rd_ready = 1'b1;
    cap(4'b0000, 32'h5, 32'h3, 32'h8, 1'b0);
    step();
    ta.cap_en = 1'b0;
    check("basic_valid", ta.rd_valid, 1);
    check("basic_result", ta.rd_result, 32'h8);
    check("basic_seq", ta.rd_seq, 0);
    check("basic_zerr", ta.rd_zero_err, 0);
    check("basic_in_a", ta.rd_in_a, 32'h5);
    step();
    check("basic_empty", ta.empty, 1);

    // Zero-flag mismatches in both directions; seq continues at 1
    ta.rd_ready = 1'b0;
    cap(4'h2, 32'h7, 32'h7, 32'h0, 1'b0);
    step();
    cap(4'h3, 32'h1, 32'h0, 32'h1, 1'b1);
    step();
    ta.cap_en = 1'b0;
    check("zc_count", ta.count, 2);
    check("zc0_zerr", ta.rd_zero_err, 1);
    check("zc0_seq", ta.rd_seq, 1);
    check("zc0_op", ta.rd_alu_op, 4'h2);
    ta.rd_ready = 1'b1;
    step();
    check("zc1_zerr", ta.rd_zero_err, 1);
    check("zc1_result", ta.rd_result, 32'h1);
    check("zc1_seq", ta.rd_seq, 2);
    step();
    check("zc_empty", ta.empty, 1);
    ta.rd_ready = 1'b0;

    // Overflow: 10 captures into 8 entries
    ta.clear = 1'b1;
    step();
    ta.clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cap(4'h1, 32'(i), 32'h0, 32'(100 + i), 1'b0);
      step();
    end
    ta.cap_en = 1'b0;
    check("ovf_full", ta.full, 1);
    check("ovf_count", ta.count, 8);
    check("ovf_drop", ta.drop_cnt, 2);
    check("ovf_head_seq", ta.rd_seq, 0);
    step();
    check("ovf_hold_seq", ta.rd_seq, 0);

    // Push+pop while full: next seq is 10, no drop
    cap(4'h4, 32'h0, 32'h0, 32'd200, 1'b0);
    ta.rd_ready = 1'b1;
    step();
    ta.cap_en   = 1'b0;
    ta.rd_ready = 1'b0;
    check("fpp_count", ta.count, 8);
    check("fpp_drop", ta.drop_cnt, 2);
    ta.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_seq", ta.rd_seq, (i < 7) ? 64'(i + 1) : 64'd10);
      check("drain_result", ta.rd_result, (i < 7) ? 64'(101 + i) : 64'd200);
      step();
    end
    check("drain_empty", ta.empty, 1);
    ta.rd_ready = 1'b0;

    // Pointer wrap with occupancy held at 3
    ta.clear = 1'b1;
    step();
    ta.clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap(4'h5, 32'h0, 32'h0, 32'(300 + i), 1'b0);
      step();
    end
    ta.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("wrap_head", ta.rd_result, 64'(300 + i));
      check("wrap_count", ta.count, 3);
      cap(4'h5, 32'h0, 32'h0, 32'(303 + i), 1'b0);
      step();
    end
    ta.cap_en   = 1'b0;
    ta.rd_ready = 1'b0;
    check("wrap_final_head", ta.rd_result, 320);
    check("wrap_final_seq", ta.rd_seq, 20);

    // Clear together with a capture
    ta.clear = 1'b1;
    step();
    ta.clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cap(4'h6, 32'h0, 32'h0, 32'(i), 1'b0);
      step();
    end
    ta.cap_en   = 1'b0;
    ta.rd_ready = 1'b1;
    step();
    step();
    step();
    ta.rd_ready = 1'b0;
    check("pre_clr_count", ta.count, 5);
    check("pre_clr_drop", ta.drop_cnt, 1);
    ta.clear = 1'b1;
    ta.rd_ready = 1'b1;
    cap(4'h7, 32'h0, 32'h0, 32'h99, 1'b0);
    step();
    ta.clear    = 1'b0;
    ta.rd_ready = 1'b0;
    ta.cap_en   = 1'b0;
    check("clr_count", ta.count, 0);
    check("clr_drop", ta.drop_cnt, 0);
    check("clr_empty", ta.empty, 1);
    cap(4'h8, 32'h0, 32'h0, 32'h55, 1'b0);
    step();
    ta.cap_en = 1'b0;
    check("clr_next_seq", ta.rd_seq, 0);
    check("clr_next_valid", ta.rd_valid, 1);

    // Same again, with reset and clear together
    for (int i = 0; i < 8; i++) begin
      cap(4'h9, 32'h0, 32'h0, 32'(i), 1'b0);
      step();
    end
    ta.cap_en   = 1'b0;
    ta.rd_ready = 1'b1;
    step();
    step();
    step();
    ta.rd_ready = 1'b0;
    check("pre_rst_count", ta.count, 5);
    check("pre_rst_drop", ta.drop_cnt, 1);
    reset    = 1'b1;
    ta.clear = 1'b1;
    cap(4'ha, 32'h0, 32'h0, 32'h77, 1'b0);
    step();
    reset     = 1'b0;
    ta.clear  = 1'b0;
    ta.cap_en = 1'b0;
    check("rstc_count", ta.count, 0);
    check("rstc_drop", ta.drop_cnt, 0);
    check("rstc_valid", ta.rd_valid, 0);
    cap(4'hb, 32'h0, 32'h0, 32'h66, 1'b0);
    step();
    ta.cap_en = 1'b0;
    check("rstc_next_seq", ta.rd_seq, 0);
    check("rstc_next_result", ta.rd_result, 32'h66);

    // 4-bit sequence wraps 15 -> 0 on the 17th capture
    tb4.cap_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 15) check("seq4_15", tb4.rd_seq, 15);
    end
    tb4.cap_en = 1'b0;
    check("seq4_wrap", tb4.rd_seq, 0);
    check("seq4_drop", tb4.drop_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_trace_buffer.md
ALU_TRACE_BUFFER -- requirements
Module: alu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter SEQ_W, default 16, meaning the width of the sequence and drop counters.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 clear  input  1  synchronous flush of FIFO and counters.
REQ-007 cap_en  input  1  sample the ALU signals this cycle.
REQ-008 alu_op  input  4  ALU operation being observed.
REQ-009 in_a  input  32  ALU operand A.
REQ-010 in_b  input  32  ALU operand B.
REQ-011 result  input  32  ALU result.
REQ-012 zero  input  1  ALU zero flag.
REQ-013 rd_valid  output  1  head entry available.
REQ-014 rd_ready  input  1  consumer accepts the head entry.
REQ-015 rd_alu_op, rd_in_a, rd_in_b, rd_result, rd_zero  output  4/32/32/32/1  captured fields of the head entry.
REQ-016 rd_zero_err  output  1  head entry had zero != (result == 0).
REQ-017 rd_seq  output  SEQ_W  sequence number of the head entry.
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 full, empty  output  1  occupancy == DEPTH, occupancy == 0.
REQ-020 drop_cnt  output  SEQ_W  number of captures lost to a full FIFO.

Function
REQ-021 Capture: a push SHALL occur when cap_en=1 and (full=0, or a pop occurs in the same cycle).
- Entry = {alu_op, in_a, in_b, result, zero, zero_err, seq_ctr}.
- Fields are sampled at that rising edge.
REQ-022 zero_err SHALL equal zero XOR (result == 32'h0), computed at capture.
REQ-023 seq_ctr SHALL increment by 1 on every cycle with cap_en=1, whether pushed or dropped, and SHALL wrap from all-ones to 0.
REQ-024 A cycle with cap_en=1, full=1 and no pop SHALL drop the sample.
- drop_cnt increments, saturating at all-ones.
- FIFO contents are unchanged.
REQ-025 The read port SHALL be first-word-fall-through.
- rd_valid = !empty.
- rd_* present the head entry combinationally from storage.
- rd_* are don't-care when rd_valid=0.
REQ-026 A pop SHALL occur when rd_valid=1 and rd_ready=1; rd_ready with empty=1 has no effect.
REQ-027 Latency: an entry pushed at edge N SHALL appear on rd_* after edge N, i.e. rd_valid=1 in cycle N+1 when the FIFO was empty before the push.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, including when full=1 (no drop) or count=1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; FIFO order is strictly oldest-first.
REQ-030 count, full and empty SHALL be registered-state derived and consistent in every cycle.
REQ-031 clear=1 SHALL set the pointers, count, seq_ctr and drop_cnt to 0.
- A same-cycle capture or pop is ignored: no push, no seq increment, no drop count.
REQ-032 rd_valid SHALL never deassert without a pop, clear or reset.
- rd_* SHALL NOT change while rd_valid=1 and rd_ready=0.

Reset
REQ-033 reset=1 SHALL take priority over clear and all other inputs.
REQ-034 reset SHALL set: count=0, empty=1, full=0, rd_valid=0, drop_cnt=0, seq_ctr=0, pointers=0.
REQ-035 Storage contents need not be reset.
REQ-036 reset asserted mid-stream SHALL discard all entries; the first capture after reset gets rd_seq=0.

Verification
REQ-037 Basic capture:
- Stimulus: after reset, cap_en=1 one cycle with alu_op=4'b0000, in_a=32'h5, in_b=32'h3, result=32'h8, zero=0; rd_ready=1.
- Required response: next cycle rd_valid=1, rd_result=32'h8, rd_seq=0, rd_zero_err=0; the cycle after, empty=1.
REQ-038 Zero check:
- Stimulus: capture result=32'h0 with zero=0, then result=32'h1 with zero=1.
- Required response: both entries read back with rd_zero_err=1.
REQ-039 Overflow:
- Stimulus: DEPTH=8, rd_ready=0, cap_en=1 for 10 cycles.
- Required response: full=1, count=8, drop_cnt=2.
- Draining yields rd_seq 0..7 in order, then empty=1.
REQ-040 Full push+pop:
- Stimulus: while full, cap_en=1 and rd_ready=1 for one cycle.
- Required response: count stays 8, drop_cnt unchanged, new tail entry has the next seq.
REQ-041 Wrap:
- Stimulus: 20 push/pop pairs, occupancy kept at 3.
- Required response: data order preserved across pointer wrap.
- Stimulus: SEQ_W=4 and 17 captures.
- Required response: seq wraps 15->0.
REQ-042 Clear and reset mid-operation:
- Stimulus: 5 entries and drop_cnt=1, then clear=1 together with cap_en=1.
- Required response: next cycle count=0, drop_cnt=0; next capture has rd_seq=0.
- Stimulus: repeat with reset=1 and clear=1 together.
- Required response: same result.
